// File: rtl/cdb_pkg.sv
// Shared types and default widths for the common-data-bus arbiter.
package cdb_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int ROB_WIDTH_DEF  = 4;
    localparam int FIFO_WIDTH_DEF = 1;
    localparam int VALUE_WIDTH    = 32;

    // Which execution-side port a broadcast came from.
    typedef enum logic {
        SRC_RS  = 1'b0,
        SRC_LSB = 1'b1
    } cdb_src_t;

    // One completed result waiting for its broadcast slot.
    typedef struct packed {
        logic [ROB_WIDTH_DEF-1:0]  rob_index;
        logic [VALUE_WIDTH-1:0]    value;
        logic [ADDR_WIDTH_DEF-1:0] next_pc;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// Small per-requester result queue with synchronous flush and a global stall.
module cdb_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH_LOG2 = FIFO_WIDTH_DEF
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    input  logic       flush_in,
    input  logic       push,
    input  cdb_entry_t push_data,
    input  logic       pop,
    output cdb_entry_t head,
    output logic       empty,
    output logic       full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    cdb_entry_t             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2:0]    count;
    logic                   do_push;
    logic                   do_pop;

    // Full looks only at the registered count, so a same-cycle pop never frees a slot.
    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full && rdy_in && !flush_in;
    assign do_pop  = pop && !empty && rdy_in && !flush_in;

    // Pointer and occupancy bookkeeping; flush wins over stall.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage write at the tail.
    // NOTE: the storage array has no reset; validity is tracked by count, which is reset.
    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Picks one queued RS or LSB result per cycle and drives it, registered, onto the CDB.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int RoB_WIDTH  = ROB_WIDTH_DEF,
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,

    input  logic                  RSCDB_en,
    input  logic [RoB_WIDTH-1:0]  RSCDB_RoB_index,
    input  logic [31:0]           RSCDB_value,
    input  logic [ADDR_WIDTH-1:0] RSCDB_next_pc,
    output logic                  RSCDB_full,

    input  logic                  LSBCDB_en,
    input  logic [RoB_WIDTH-1:0]  LSBCDB_RoB_index,
    input  logic [31:0]           LSBCDB_value,
    output logic                  LSBCDB_full,

    output logic                  CDB_en,
    output logic [RoB_WIDTH-1:0]  CDB_RoB_index,
    output logic [31:0]           CDB_value,
    output logic [ADDR_WIDTH-1:0] CDB_next_pc,
    output logic                  CDB_src
);

    cdb_entry_t rs_push_entry;
    cdb_entry_t lsb_push_entry;
    cdb_entry_t rs_head;
    cdb_entry_t lsb_head;
    cdb_entry_t grant_entry;
    logic       rs_empty;
    logic       lsb_empty;
    logic       rs_cnt_full;
    logic       lsb_cnt_full;
    logic       grant_valid;
    cdb_src_t   grant_src;
    cdb_src_t   last_grant;
    cdb_src_t   cdb_src_q;

    assign rs_push_entry  = '{rob_index: RSCDB_RoB_index, value: RSCDB_value, next_pc: RSCDB_next_pc};
    // Load/store results carry no control-flow information.
    assign lsb_push_entry = '{rob_index: LSBCDB_RoB_index, value: LSBCDB_value, next_pc: '0};

    cdb_fifo #(.DEPTH_LOG2(FIFO_WIDTH)) u_rs_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .flush_in  (flush_in),
        .push      (RSCDB_en),
        .push_data (rs_push_entry),
        .pop       (grant_valid && (grant_src == SRC_RS)),
        .head      (rs_head),
        .empty     (rs_empty),
        .full      (rs_cnt_full)
    );

    cdb_fifo #(.DEPTH_LOG2(FIFO_WIDTH)) u_lsb_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .flush_in  (flush_in),
        .push      (LSBCDB_en),
        .push_data (lsb_push_entry),
        .pop       (grant_valid && (grant_src == SRC_LSB)),
        .head      (lsb_head),
        .empty     (lsb_empty),
        .full      (lsb_cnt_full)
    );

    // A stalled block reports full so producers hold their results.
    assign RSCDB_full  = rs_cnt_full || !rdy_in;
    assign LSBCDB_full = lsb_cnt_full || !rdy_in;

    // Grant selection: lone requester, then a full queue, then round-robin.
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_RS;
        if (rdy_in && !flush_in) begin
            if (!rs_empty && !lsb_empty) begin
                grant_valid = 1'b1;
                if (rs_cnt_full && !lsb_cnt_full)
                    grant_src = SRC_RS;
                else if (lsb_cnt_full && !rs_cnt_full)
                    grant_src = SRC_LSB;
                else
                    grant_src = (last_grant == SRC_RS) ? SRC_LSB : SRC_RS;
            end else if (!rs_empty) begin
                grant_valid = 1'b1;
                grant_src   = SRC_RS;
            end else if (!lsb_empty) begin
                grant_valid = 1'b1;
                grant_src   = SRC_LSB;
            end
        end
    end

    assign grant_entry = (grant_src == SRC_LSB) ? lsb_head : rs_head;

    // Broadcast registers and round-robin history; data holds when nothing is granted.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            CDB_en        <= 1'b0;
            CDB_RoB_index <= '0;
            CDB_value     <= '0;
            CDB_next_pc   <= '0;
            cdb_src_q     <= SRC_RS;
            last_grant    <= SRC_LSB;
        end else if (flush_in) begin
            CDB_en <= 1'b0;
        end else if (rdy_in) begin
            CDB_en <= grant_valid;
            if (grant_valid) begin
                CDB_RoB_index <= grant_entry.rob_index;
                CDB_value     <= grant_entry.value;
                CDB_next_pc   <= grant_entry.next_pc;
                cdb_src_q     <= grant_src;
                last_grant    <= grant_src;
            end
        end
    end

    assign CDB_src = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int DEPTH = 2;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        RSCDB_en;
    logic [3:0]  RSCDB_RoB_index;
    logic [31:0] RSCDB_value;
    logic [31:0] RSCDB_next_pc;
    logic        RSCDB_full;
    logic        LSBCDB_en;
    logic [3:0]  LSBCDB_RoB_index;
    logic [31:0] LSBCDB_value;
    logic        LSBCDB_full;
    logic        CDB_en;
    logic [3:0]  CDB_RoB_index;
    logic [31:0] CDB_value;
    logic [31:0] CDB_next_pc;
    logic        CDB_src;

    cdb_arbiter dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .flush_in         (flush_in),
        .RSCDB_en         (RSCDB_en),
        .RSCDB_RoB_index  (RSCDB_RoB_index),
        .RSCDB_value      (RSCDB_value),
        .RSCDB_next_pc    (RSCDB_next_pc),
        .RSCDB_full       (RSCDB_full),
        .LSBCDB_en        (LSBCDB_en),
        .LSBCDB_RoB_index (LSBCDB_RoB_index),
        .LSBCDB_value     (LSBCDB_value),
        .LSBCDB_full      (LSBCDB_full),
        .CDB_en           (CDB_en),
        .CDB_RoB_index    (CDB_RoB_index),
        .CDB_value        (CDB_value),
        .CDB_next_pc      (CDB_next_pc),
        .CDB_src          (CDB_src)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: two bounded queues plus the expected broadcast registers.
    cdb_entry_t  rs_q[$];
    cdb_entry_t  lsb_q[$];
    bit          m_last;
    bit          m_en;
    logic [3:0]  m_idx;
    logic [31:0] m_val;
    logic [31:0] m_pc;
    bit          m_src;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cdb_entry_t mk(input logic [3:0] i, input logic [31:0] v, input logic [31:0] p);
        cdb_entry_t e;
        e.rob_index = i;
        e.value     = v;
        e.next_pc   = p;
        return e;
    endfunction

    task automatic model_reset();
        rs_q.delete();
        lsb_q.delete();
        m_last = 1'b1;
        m_en   = 1'b0;
        m_idx  = '0;
        m_val  = '0;
        m_pc   = '0;
        m_src  = 1'b0;
    endtask

    task automatic model_step(input bit rdy, input bit flush, input bit rsp, input cdb_entry_t rse,
                              input bit lsbp, input cdb_entry_t lsbe);
        int rs_n;
        int lsb_n;
        bit g;
        bit src;
        cdb_entry_t e;
        rs_n  = rs_q.size();
        lsb_n = lsb_q.size();
        g     = 1'b0;
        src   = 1'b0;
        if (flush) begin
            rs_q.delete();
            lsb_q.delete();
            m_en = 1'b0;
            return;
        end
        if (!rdy) return;
        if (rs_n > 0 && lsb_n > 0) begin
            g = 1'b1;
            if (rs_n == DEPTH && lsb_n != DEPTH)      src = 1'b0;
            else if (lsb_n == DEPTH && rs_n != DEPTH) src = 1'b1;
            else                                      src = !m_last;
        end else if (rs_n > 0) begin
            g = 1'b1; src = 1'b0;
        end else if (lsb_n > 0) begin
            g = 1'b1; src = 1'b1;
        end
        if (g) begin
            e = src ? lsb_q.pop_front() : rs_q.pop_front();
            m_en = 1'b1; m_idx = e.rob_index; m_val = e.value; m_pc = e.next_pc;
            m_src = src; m_last = src;
        end else begin
            m_en = 1'b0;
        end
        if (rsp && rs_n < DEPTH) rs_q.push_back(rse);
        if (lsbp && lsb_n < DEPTH) lsb_q.push_back(mk(lsbe.rob_index, lsbe.value, 32'h0));
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_cdb_en"},  CDB_en,        m_en);
        check({pfx, "_cdb_idx"}, CDB_RoB_index, m_idx);
        check({pfx, "_cdb_val"}, CDB_value,     m_val);
        check({pfx, "_cdb_pc"},  CDB_next_pc,   m_pc);
        check({pfx, "_cdb_src"}, CDB_src,       m_src);
    endtask

    // One clock cycle: drive legal inputs, check full flags, advance model, check broadcast.
    task automatic cycle(input string pfx, input bit rdy, input bit flush, input bit rsp, input cdb_entry_t rse,
                         input bit lsbp, input cdb_entry_t lsbe);
        bit rs_ok;
        bit lsb_ok;
        rs_ok  = rsp && rdy && (rs_q.size() < DEPTH);
        lsb_ok = lsbp && rdy && (lsb_q.size() < DEPTH);
        rdy_in           = rdy;
        flush_in         = flush;
        RSCDB_en         = rs_ok;
        RSCDB_RoB_index  = rse.rob_index;
        RSCDB_value      = rse.value;
        RSCDB_next_pc    = rse.next_pc;
        LSBCDB_en        = lsb_ok;
        LSBCDB_RoB_index = lsbe.rob_index;
        LSBCDB_value     = lsbe.value;
        #1;
        check({pfx, "_rs_full"},  RSCDB_full,  (rs_q.size() == DEPTH) || !rdy);
        check({pfx, "_lsb_full"}, LSBCDB_full, (lsb_q.size() == DEPTH) || !rdy);
        model_step(rdy, flush, rs_ok, rse, lsb_ok, lsbe);
        @(posedge clk_in);
        #1;
        check_outputs(pfx);
    endtask

    task automatic idle(input string pfx);
        cycle(pfx, 1'b1, 1'b0, 1'b0, mk(0, 0, 0), 1'b0, mk(0, 0, 0));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        rdy_in = 1'b1; flush_in = 1'b0; RSCDB_en = 1'b0; LSBCDB_en = 1'b0;
        rst_in = 1'b0;
        #2;
        model_reset();
        check_outputs("rst");
        check("rst_rs_full",  RSCDB_full,  1'b0);
        check("rst_lsb_full", LSBCDB_full, 1'b0);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
        RSCDB_en = 1'b0; RSCDB_RoB_index = '0; RSCDB_value = '0; RSCDB_next_pc = '0;
        LSBCDB_en = 1'b0; LSBCDB_RoB_index = '0; LSBCDB_value = '0;
        #1;

        // Single RS push broadcasts one cycle later, then goes idle.
        do_reset();
        cycle("t1", 1'b1, 1'b0, 1'b1, mk(3, 32'h11, 32'h100), 1'b0, mk(0, 0, 0));
        check("t1_en_latency", CDB_en, 1'b0);
        idle("t1");
        check("t1_en", CDB_en, 1'b1);
        check("t1_idx", CDB_RoB_index, 4'd3);
        check("t1_val", CDB_value, 32'h11);
        check("t1_pc", CDB_next_pc, 32'h100);
        check("t1_src", CDB_src, 1'b0);
        idle("t1");
        check("t1_en_off", CDB_en, 1'b0);

        // Simultaneous pushes after reset: RS wins the first tie.
        do_reset();
        cycle("t2", 1'b1, 1'b0, 1'b1, mk(1, 32'hA1, 32'h200), 1'b1, mk(2, 32'hB2, 0));
        idle("t2");
        check("t2_first_idx", CDB_RoB_index, 4'd1);
        check("t2_first_src", CDB_src, 1'b0);
        idle("t2");
        check("t2_second_idx", CDB_RoB_index, 4'd2);
        check("t2_second_src", CDB_src, 1'b1);
        check("t2_second_pc", CDB_next_pc, 32'h0);

        // Both sources push every cycle they may.
        do_reset();
        for (int i = 0; i < 8; i++)
            cycle("t3", 1'b1, 1'b0, 1'b1, mk(4'(i), 32'h1000 + i, 32'h3000 + i),
                  1'b1, mk(4'(i + 8), 32'h2000 + i, 0));
        for (int i = 0; i < 4; i++) idle("t3d");

        // Full LSB queue overrides round-robin order.
        do_reset();
        cycle("t4", 1'b1, 1'b0, 1'b1, mk(4, 32'h44, 32'h40), 1'b1, mk(5, 32'h55, 0));
        cycle("t4", 1'b1, 1'b0, 1'b1, mk(6, 32'h66, 32'h60), 1'b1, mk(8, 32'h88, 0));
        check("t4_rs_first", CDB_RoB_index, 4'd4);
        check("t4_lsb_full", LSBCDB_full, 1'b1);
        idle("t4");
        check("t4_lsb_grant_src", CDB_src, 1'b1);
        check("t4_lsb_grant_idx", CDB_RoB_index, 4'd5);
        check("t4_lsb_full_drop", LSBCDB_full, 1'b0);
        for (int i = 0; i < 3; i++) idle("t4d");

        // Flush with a concurrent RS push: nothing further is broadcast.
        do_reset();
        cycle("t5", 1'b1, 1'b0, 1'b1, mk(1, 32'h1, 32'h10), 1'b1, mk(2, 32'h2, 0));
        cycle("t5", 1'b1, 1'b0, 1'b1, mk(3, 32'h3, 32'h30), 1'b1, mk(4, 32'h4, 0));
        cycle("t5f", 1'b1, 1'b1, 1'b1, mk(7, 32'h77, 32'h70), 1'b0, mk(0, 0, 0));
        check("t5_en_after_flush", CDB_en, 1'b0);
        check("t5_rs_full", RSCDB_full, 1'b0);
        check("t5_lsb_full", LSBCDB_full, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle("t5d");
            check("t5_no_bcast", CDB_en, 1'b0);
        end

        // Stall with entries queued, then resume in order.
        do_reset();
        cycle("t6", 1'b1, 1'b0, 1'b1, mk(1, 32'h1, 32'h10), 1'b1, mk(2, 32'h2, 0));
        cycle("t6", 1'b1, 1'b0, 1'b1, mk(3, 32'h3, 32'h30), 1'b1, mk(4, 32'h4, 0));
        for (int i = 0; i < 3; i++) begin
            cycle("t6s", 1'b0, 1'b0, 1'b0, mk(0, 0, 0), 1'b0, mk(0, 0, 0));
            check("t6_hold_en", CDB_en, 1'b1);
            check("t6_hold_idx", CDB_RoB_index, 4'd1);
            check("t6_stall_rs_full", RSCDB_full, 1'b1);
            check("t6_stall_lsb_full", LSBCDB_full, 1'b1);
        end
        idle("t6r");
        check("t6_resume_idx", CDB_RoB_index, 4'd2);
        for (int i = 0; i < 3; i++) idle("t6r");

        // Randomized traffic with stalls, flushes and occasional mid-run resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit rdy;
            bit fl;
            if ($urandom_range(0, 399) == 0) do_reset();
            rdy = ($urandom_range(0, 5) != 0);
            fl  = ($urandom_range(0, 39) == 0);
            cycle("rnd", rdy, fl,
                  $urandom_range(0, 2) != 0, mk(4'($urandom), $urandom, $urandom),
                  $urandom_range(0, 2) != 0, mk(4'($urandom), $urandom, $urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
